// File: rtl/motor_pkg.sv
// Shared types and constants for the H-bridge PWM drive.
package motor_pkg;

    localparam int DUTY_W = 8;

    // Direction encoding as presented by the command register block
    localparam logic FWD = 1'b0;
    localparam logic REV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } ch_state_t;

    // Per-side command as seen by a channel
    typedef struct packed {
        logic              en;
        logic              dir;
        logic [DUTY_W-1:0] duty;
    } ch_cmd_t;

    // Per-side registered bridge drive and status
    typedef struct packed {
        logic in1;
        logic in2;
        logic busy;
    } ch_drv_t;

endpackage

// File: rtl/pwm_motor_drive_if.sv
// Command inputs from the register block and H-bridge outputs to the pins.
interface pwm_motor_drive_if;
    import motor_pkg::*;

    logic [DUTY_W-1:0] PWM_DUTY_R;
    logic [DUTY_W-1:0] PWM_DUTY_L;
    logic              PWM_EN_R;
    logic              PWM_EN_L;
    logic              PWM_DIR_R;
    logic              PWM_DIR_L;
    logic              MOT_IN1_R;
    logic              MOT_IN2_R;
    logic              MOT_IN1_L;
    logic              MOT_IN2_L;
    logic              PERIOD_START;
    logic              BUSY_R;
    logic              BUSY_L;

    // Command source side (register block / bench)
    modport master (
        output PWM_DUTY_R, PWM_DUTY_L, PWM_EN_R, PWM_EN_L, PWM_DIR_R, PWM_DIR_L,
        input  MOT_IN1_R, MOT_IN2_R, MOT_IN1_L, MOT_IN2_L, PERIOD_START, BUSY_R, BUSY_L
    );

    // PWM drive side
    modport slave (
        input  PWM_DUTY_R, PWM_DUTY_L, PWM_EN_R, PWM_EN_L, PWM_DIR_R, PWM_DIR_L,
        output MOT_IN1_R, MOT_IN2_R, MOT_IN1_L, MOT_IN2_L, PERIOD_START, BUSY_R, BUSY_L
    );

endinterface

// File: rtl/pwm_channel.sv
// One H-bridge side: command FSM with dead-time on reversal, duty/direction
// shadows that only move at period boundaries, compare and bridge mapping.
module pwm_channel
    import motor_pkg::*;
#(
    parameter int DEADTIME_PERIODS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boundary,
    input  logic [DUTY_W-1:0] cnt,
    input  ch_cmd_t           cmd,
    output ch_drv_t           drv
);

    localparam logic [7:0] DCNT_INIT = 8'(DEADTIME_PERIODS - 1);

    ch_state_t         state;
    logic [DUTY_W-1:0] duty_q;
    logic              dir_q;
    logic [7:0]        dcnt;
    logic              pwm;

    // Only RUN ever drives; duty 255 still leaves one low count per period
    assign pwm = (state == RUN) && (cnt < duty_q);

    // Command FSM, evaluated at period boundaries only; en beats dir
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            duty_q <= '0;
            dir_q  <= FWD;
            dcnt   <= '0;
        end else if (boundary) begin
            case (state)
                IDLE: begin
                    // Starting from coast needs no dead time, whatever dir_q was
                    if (cmd.en) begin
                        state  <= RUN;
                        dir_q  <= cmd.dir;
                        duty_q <= cmd.duty;
                    end
                end
                RUN: begin
                    if (!cmd.en) begin
                        state <= IDLE;
                    end else if (cmd.dir != dir_q) begin
                        state <= DEAD;
                        dcnt  <= DCNT_INIT;
                    end else begin
                        duty_q <= cmd.duty;
                    end
                end
                DEAD: begin
                    // Dead time runs to completion even if dir flips back
                    if (!cmd.en) begin
                        state <= IDLE;
                    end else if (dcnt == 8'd0) begin
                        state  <= RUN;
                        dir_q  <= cmd.dir;
                        duty_q <= cmd.duty;
                    end else begin
                        dcnt <= dcnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered bridge pins: at most one leg driven, both low when coasting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drv <= '0;
        end else begin
            drv.in1  <= pwm && (dir_q == FWD);
            drv.in2  <= pwm && (dir_q == REV);
            drv.busy <= (state == DEAD);
        end
    end

endmodule

// File: rtl/pwm_motor_drive.sv
// Dual-channel H-bridge PWM generator: shared prescaler and 8-bit period
// counter, boundary strobe, PERIOD_START, and one pwm_channel per side.
module pwm_motor_drive
    import motor_pkg::*;
#(
    parameter int PRESCALE         = 195,
    parameter int DEADTIME_PERIODS = 4
) (
    input  logic             PCLK,
    input  logic             PRESET,
    pwm_motor_drive_if.slave bus
);

    localparam int NUM_CH = 2;  // 0 = right, 1 = left
    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);

    logic [PCNT_W-1:0] pcnt;
    logic [DUTY_W-1:0] cnt;
    logic              tick;
    logic              boundary;
    logic              bnd_q;

    ch_cmd_t [NUM_CH-1:0] cmd;
    ch_drv_t [NUM_CH-1:0] drv;

    assign tick     = (pcnt == PCNT_MAX);
    assign boundary = tick && (cnt == {DUTY_W{1'b1}});

    // Prescaler: one count step every PRESCALE clocks
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)    pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + 1'b1;
    end

    // Period counter, free-running 0..255
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)    cnt <= '0;
        else if (tick) cnt <= cnt + 1'b1;
    end

    // PERIOD_START is delayed one extra cycle so it lines up with the first
    // registered drive cycle of the new period
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            bnd_q            <= 1'b0;
            bus.PERIOD_START <= 1'b0;
        end else begin
            bnd_q            <= boundary;
            bus.PERIOD_START <= bnd_q;
        end
    end

    assign cmd[0] = '{en: bus.PWM_EN_R, dir: bus.PWM_DIR_R, duty: bus.PWM_DUTY_R};
    assign cmd[1] = '{en: bus.PWM_EN_L, dir: bus.PWM_DIR_L, duty: bus.PWM_DUTY_L};

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            pwm_channel #(
                .DEADTIME_PERIODS(DEADTIME_PERIODS)
            ) u_ch (
                .clk      (PCLK),
                .rst      (PRESET),
                .boundary (boundary),
                .cnt      (cnt),
                .cmd      (cmd[g]),
                .drv      (drv[g])
            );
        end
    endgenerate

    assign bus.MOT_IN1_R = drv[0].in1;
    assign bus.MOT_IN2_R = drv[0].in2;
    assign bus.BUSY_R    = drv[0].busy;
    assign bus.MOT_IN1_L = drv[1].in1;
    assign bus.MOT_IN2_L = drv[1].in2;
    assign bus.BUSY_L    = drv[1].busy;

endmodule

// File: tb/tb_pwm_motor_drive.sv
// Bench for pwm_motor_drive with PRESCALE = 1, DEADTIME_PERIODS = 2.
module tb_pwm_motor_drive;

    localparam int PS = 1;
    localparam int DT = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    pwm_motor_drive_if bus();

    pwm_motor_drive #(.PRESCALE(PS), .DEADTIME_PERIODS(DT)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;
    int ecnt;   // rising edges since reset release

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a period plan per side, decided at each boundary from the
    // commands in force just before it; the 256 cycles after a boundary
    // play that plan with phase 0..255.
    int m_st[2], m_dir[2], m_duty[2], m_dc[2];
    int p_en[2], p_dir[2], p_duty[2];

    always @(negedge PCLK) begin
        int n, ph, eps;
        int e1[2], e2[2], eb[2], a1[2], a2[2], ab[2];
        a1[0] = int'(bus.MOT_IN1_R); a2[0] = int'(bus.MOT_IN2_R); ab[0] = int'(bus.BUSY_R);
        a1[1] = int'(bus.MOT_IN1_L); a2[1] = int'(bus.MOT_IN2_L); ab[1] = int'(bus.BUSY_L);
        n = ecnt;
        eps = 0;
        if (n == 0) begin
            for (int c = 0; c < 2; c++) begin
                m_st[c] = M_IDLE; m_dir[c] = 0; m_duty[c] = 0; m_dc[c] = 0;
                e1[c] = 0; e2[c] = 0; eb[c] = 0;
            end
        end else begin
            ph  = (n - 1) % 256;
            eps = (n > 256 && ph == 0) ? 1 : 0;
            for (int c = 0; c < 2; c++) begin
                e1[c] = (m_st[c] == M_RUN && m_dir[c] == 0 && ph < m_duty[c]) ? 1 : 0;
                e2[c] = (m_st[c] == M_RUN && m_dir[c] == 1 && ph < m_duty[c]) ? 1 : 0;
                eb[c] = (m_st[c] == M_DEAD) ? 1 : 0;
            end
            if (n % 256 == 0) begin
                for (int c = 0; c < 2; c++) begin
                    if (p_en[c] == 0) begin
                        m_st[c] = M_IDLE;
                    end else if (m_st[c] == M_IDLE ||
                                 (m_st[c] == M_DEAD && m_dc[c] == 0)) begin
                        m_st[c] = M_RUN; m_dir[c] = p_dir[c]; m_duty[c] = p_duty[c];
                    end else if (m_st[c] == M_DEAD) begin
                        m_dc[c] = m_dc[c] - 1;
                    end else if (p_dir[c] != m_dir[c]) begin
                        m_st[c] = M_DEAD; m_dc[c] = DT - 1;
                    end else begin
                        m_duty[c] = p_duty[c];
                    end
                end
            end
        end
        check($sformatf("in1_r@%0d", n), a1[0], e1[0]);
        check($sformatf("in2_r@%0d", n), a2[0], e2[0]);
        check($sformatf("busy_r@%0d", n), ab[0], eb[0]);
        check($sformatf("in1_l@%0d", n), a1[1], e1[1]);
        check($sformatf("in2_l@%0d", n), a2[1], e2[1]);
        check($sformatf("busy_l@%0d", n), ab[1], eb[1]);
        check($sformatf("pstart@%0d", n), int'(bus.PERIOD_START), eps);
        for (int c = 0; c < 2; c++) begin
            checks++;
            assert (!(a1[c] == 1 && a2[c] == 1)) else begin
                errors++;
                $display("FAIL shoot_through side%0d@%0d: got in1=1 in2=1 required not both", c, n);
            end
        end
        p_en[0] = int'(bus.PWM_EN_R); p_dir[0] = int'(bus.PWM_DIR_R); p_duty[0] = int'(bus.PWM_DUTY_R);
        p_en[1] = int'(bus.PWM_EN_L); p_dir[1] = int'(bus.PWM_DIR_L); p_duty[1] = int'(bus.PWM_DUTY_L);
    end

    task automatic goto(input int n);
        int g = 0;
        while (ecnt < n && g < 20000) begin
            @(posedge PCLK); #1; g++;
        end
        check("goto", ecnt, n);
    endtask

    task automatic measure(input int cyc, output int s1r, output int s2r,
                           output int s1l, output int sbr, output int sps);
        s1r = 0; s2r = 0; s1l = 0; sbr = 0; sps = 0;
        repeat (cyc) begin
            @(posedge PCLK); #1;
            s1r += int'(bus.MOT_IN1_R); s2r += int'(bus.MOT_IN2_R);
            s1l += int'(bus.MOT_IN1_L); sbr += int'(bus.BUSY_R);
            sps += int'(bus.PERIOD_START);
        end
    endtask

    task automatic all_zero(input string tag);
        check({tag, " in1_r"}, int'(bus.MOT_IN1_R), 0);
        check({tag, " in2_r"}, int'(bus.MOT_IN2_R), 0);
        check({tag, " in1_l"}, int'(bus.MOT_IN1_L), 0);
        check({tag, " in2_l"}, int'(bus.MOT_IN2_L), 0);
        check({tag, " busy_r"}, int'(bus.BUSY_R), 0);
        check({tag, " busy_l"}, int'(bus.BUSY_L), 0);
        check({tag, " pstart"}, int'(bus.PERIOD_START), 0);
    endtask

    initial begin
        int s1r, s2r, s1l, sbr, sps, sa, i;
        bit found;
        bus.PWM_DUTY_R = 8'd0; bus.PWM_DUTY_L = 8'd0;
        bus.PWM_EN_R = 1'b0; bus.PWM_EN_L = 1'b0;
        bus.PWM_DIR_R = 1'b0; bus.PWM_DIR_L = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        all_zero("reset");
        PRESET = 1'b0;

        // Right forward at duty 64
        bus.PWM_EN_R = 1'b1; bus.PWM_DIR_R = 1'b0; bus.PWM_DUTY_R = 8'd64;
        goto(256);
        measure(256, s1r, s2r, s1l, sbr, sps);
        check("d64 in1_r", s1r, 64);
        check("d64 in2_r", s2r, 0);
        check("d64 in1_l", s1l, 0);
        check("d64 pstart", sps, 1);

        // Duty 0 then 255
        bus.PWM_DUTY_R = 8'd0;
        goto(768);
        bus.PWM_DUTY_R = 8'd255;
        measure(256, s1r, s2r, s1l, sbr, sps);
        check("d0 in1_r", s1r, 0);
        check("d0 pstart", sps, 1);
        measure(256, s1r, s2r, s1l, sbr, sps);
        check("d255 low cycles", 256 - s1r, 1);
        check("d255 pstart", sps, 1);

        // Reversal at duty 128, flipped mid-period
        bus.PWM_DUTY_R = 8'd128;
        goto(1636);
        bus.PWM_DIR_R = 1'b1;
        measure(156, s1r, s2r, s1l, sbr, sps);
        check("rev tail in1_r", s1r, 28);
        check("rev tail in2_r", s2r, 0);
        measure(512, s1r, s2r, s1l, sbr, sps);
        check("dead busy_r", sbr, 512);
        check("dead in1_r", s1r, 0);
        check("dead in2_r", s2r, 0);
        measure(256, s1r, s2r, s1l, sbr, sps);
        check("rev in2_r", s2r, 128);
        check("rev in1_r", s1r, 0);
        check("rev busy_r", sbr, 0);

        // Left duty change mid-period
        bus.PWM_EN_L = 1'b1; bus.PWM_DIR_L = 1'b0; bus.PWM_DUTY_L = 8'd32;
        goto(2816);
        measure(100, s1r, s2r, sa, sbr, sps);
        bus.PWM_DUTY_L = 8'd200;
        measure(156, s1r, s2r, s1l, sbr, sps);
        check("l32 in1_l", sa + s1l, 32);
        measure(256, s1r, s2r, s1l, sbr, sps);
        check("l200 in1_l", s1l, 200);

        // Reset at cnt = 170 while both sides drive
        goto(3498);
        PRESET = 1'b1;
        #1;
        all_zero("midrst");
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        i = 0; found = 1'b0;
        while (!found && i < 600) begin
            @(posedge PCLK); #1; i++;
            if (bus.PERIOD_START) found = 1'b1;
        end
        check("first pstart", i, 257);
        // Right comes back reverse directly from IDLE
        check("no dead from idle", int'(bus.BUSY_R), 0);
        measure(255, s1r, s2r, s1l, sbr, sps);
        check("post rst in2_r", s2r, 127);

        // Drop enable while in DEAD
        bus.PWM_DIR_R = 1'b0;
        goto(800);
        check("dead busy", int'(bus.BUSY_R), 1);
        bus.PWM_EN_R = 1'b0;
        goto(1024);
        check("dead last", int'(bus.BUSY_R), 1);
        goto(1025);
        check("en drop idle", int'(bus.BUSY_R), 0);

        // Dir toggles back during DEAD: dead time still completes
        bus.PWM_EN_R = 1'b1;
        goto(1300);
        bus.PWM_DIR_R = 1'b1;
        goto(1600);
        bus.PWM_DIR_R = 1'b0;
        goto(2048);
        check("toggle dead busy", int'(bus.BUSY_R), 1);
        goto(2049);
        check("toggle resume busy", int'(bus.BUSY_R), 0);
        check("toggle resume in1", int'(bus.MOT_IN1_R), 1);

        // en and dir change on the same boundary: en wins
        bus.PWM_EN_R = 1'b0; bus.PWM_DIR_R = 1'b1;
        goto(2305);
        check("en prio busy", int'(bus.BUSY_R), 0);
        check("en prio in2", int'(bus.MOT_IN2_R), 0);

        // Random command churn on both sides
        repeat (3000) begin
            @(posedge PCLK); #1;
            if ($urandom_range(0, 63) == 0) bus.PWM_EN_R = ~bus.PWM_EN_R;
            if ($urandom_range(0, 63) == 0) bus.PWM_DIR_R = ~bus.PWM_DIR_R;
            if ($urandom_range(0, 63) == 0) bus.PWM_EN_L = ~bus.PWM_EN_L;
            if ($urandom_range(0, 63) == 0) bus.PWM_DIR_L = ~bus.PWM_DIR_L;
            if ($urandom_range(0, 127) == 0) bus.PWM_DUTY_R = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 127) == 0) bus.PWM_DUTY_L = 8'($urandom_range(0, 255));
        end

        @(posedge PCLK); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
